// File: rtl/w0rm_mem_bus_initiator.sv
// w0rm_mem_bus_initiator: single-outstanding CPU load/store to W0RM bus bridge.
// Each bus transaction carries a tag on the user field; only a response that
// echoes the current tag completes it. Misaligned requests are answered
// locally with an error, without touching the bus.
// Optional feature macro: W0RM_MEM_INIT_TIMEOUT_EN (WAIT timeout counter).
module w0rm_mem_bus_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [USER_WIDTH-1:0] mem_user_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [USER_WIDTH-1:0] mem_user_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Byte-offset bits below the data word; zero for an 8-bit bus.
  localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

  logic [1:0]            state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [USER_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic misalign, hit, timeout;

  assign misalign = |(req_addr_i & OFF_MASK);
  assign hit      = mem_valid_i && (mem_user_i == tag_q);

`ifdef W0RM_MEM_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // WAIT cycles without a matching response; cleared on every bus issue
  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n)                          cnt_q <= '0;
    else if (state_q == ISSUE)                 cnt_q <= '0;
    else if (state_q == WAIT && !hit && !timeout) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Transaction sequencing; a matching response beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    user_d  = user_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        write_d = req_write_i;
        if (misalign) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          addr_d  = req_addr_i;
          wdata_d = req_data_i;
          user_d  = tag_q;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (hit) begin
          rdata_d = write_q ? '0 : mem_data_i;
          err_d   = 1'b0;
          tag_d   = tag_q + 1'b1;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tag_d   = tag_q + 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      user_q  <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      user_q  <= user_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_data_o  = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_valid_o  = (state_q == ISSUE);
  assign mem_read_o   = mem_valid_o && !write_q;
  assign mem_write_o  = mem_valid_o && write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
  assign mem_user_o   = user_q;

endmodule

// File: tb/tb_w0rm_mem_bus_initiator.sv
// Self-checking bench for w0rm_mem_bus_initiator (32-bit bus, TIMEOUT_CYCLES=4).
// Timeout scenarios run only when W0RM_MEM_INIT_TIMEOUT_EN is defined.
module tb_w0rm_mem_bus_initiator;
  localparam int T = 4;
`ifdef W0RM_MEM_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        mem_clk = 1'b0;
  logic        cpu_reset_n = 1'b0;
  logic        req_valid_i = 1'b0, req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_data_i = '0;
  logic        req_ready_o, resp_valid_o, resp_err_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic        mem_valid_o, mem_read_o, mem_write_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_user_o;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = '0, mem_user_i = '0;

  w0rm_mem_bus_initiator #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .mem_clk(mem_clk), .cpu_reset_n(cpu_reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_user_i(mem_user_i)
  );

  always #5 mem_clk = ~mem_clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_tag = '0;        // number of completed bus transactions
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // One CPU transaction. dly = WAIT-cycle index of the matching bus response
  // (beyond T means the slave stays silent), stale = inject previous-tag
  // response in the first WAIT cycle, hold = RESP back-pressure cycles.
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input bit stale, input int hold);
    bit          mis = (a[1:0] != 2'b00);
    bit          to  = TO_EN && (dly > T);
    int          last;
    logic [31:0] e_data;
    bit          e_err;
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a; req_data_i = d;
    tick();
    req_valid_i = 1'b0; req_write_i = $urandom; req_addr_i = $urandom; req_data_i = $urandom;
    if (mis) begin
      chk("mis_no_bus", mem_valid_o, 0);
      e_data = '0; e_err = 1'b1;
    end else begin
      chk("issue_valid", mem_valid_o, 1);
      chk("issue_read", mem_read_o, !wr);
      chk("issue_write", mem_write_o, wr);
      chk("issue_addr", mem_addr_o, a);
      if (wr) chk("issue_data", mem_data_o, d);
      chk("issue_user", mem_user_o, exp_tag);
      last = (TO_EN && dly > T) ? T : dly;
      for (int i = 0; i <= last; i++) begin
        tick();
        if (i == 0) chk("valid_one_cycle", mem_valid_o, 0);
        chk("wait_no_resp", resp_valid_o, 0);
        mem_valid_i = 1'b0; mem_user_i = $urandom; mem_data_i = $urandom;
        if (i == dly) begin
          mem_valid_i = 1'b1; mem_user_i = exp_tag; mem_data_i = mem_val(a);
        end else if (stale && i == 0) begin
          mem_valid_i = 1'b1; mem_user_i = exp_tag - 1; mem_data_i = ~mem_val(a);
        end
      end
      e_data = (to || wr) ? 32'h0 : mem_val(a);
      e_err  = to;
      exp_tag = exp_tag + 1;
      if (wr && !to) ref_mem[a] = d;
      tick();
      mem_valid_i = 1'b0;
    end
    for (int k = 0; k <= hold; k++) begin
      chk("resp_valid", resp_valid_o, 1);
      chk("resp_data", resp_data_o, e_data);
      chk("resp_err", resp_err_o, e_err);
      chk("resp_no_req_ready", req_ready_o, 0);
      if (k == hold) resp_ready_i = 1'b1;
      tick();
    end
    resp_ready_i = 1'b0;
    chk("resp_released", resp_valid_o, 0);
  endtask

  initial begin
    #1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_mem_valid", {mem_valid_o, mem_read_o, mem_write_o}, 0);
    chk("rst_regs", {mem_addr_o, mem_user_o}, 0);
    chk("rst_resp", {resp_data_o, resp_err_o}, 0);
    tick();
    cpu_reset_n = 1'b1;
    tick();

    // store then load of one word, zero-wait slave
    do_txn(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0, 0);
    do_txn(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0, 0);
    // misaligned: no bus cycle, tag unchanged (checked by next issue_user)
    do_txn(1'b0, 32'h4000_0002, 32'h0, 0, 1'b0, 0);
    // stale response first, correct one two cycles later
    do_txn(1'b0, 32'h4000_0010, 32'h0, 2, 1'b1, 0);
    // back-pressure in RESP
    do_txn(1'b0, 32'h4000_0020, 32'h0, 1, 1'b0, 3);
    // matching response on the exact cycle the counter hits the limit
    do_txn(1'b0, 32'h4000_0024, 32'h0, T, 1'b0, 0);
    if (TO_EN) begin
      // silent slave then late old-tag response to the next transaction
      do_txn(1'b0, 32'h4000_0030, 32'h0, 100, 1'b0, 0);
      do_txn(1'b0, 32'h4000_0010, 32'h0, 1, 1'b1, 0);
    end

    // reset pulse while waiting on the bus
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h4000_0040;
    tick();
    req_valid_i = 1'b0;
    tick();
    #2 cpu_reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready_o, 1);
    chk("mid_rst_valids", {resp_valid_o, mem_valid_o, mem_read_o, mem_write_o}, 0);
    chk("mid_rst_regs", {mem_addr_o, mem_user_o}, 0);
    chk("mid_rst_resp", {resp_data_o, resp_err_o}, 0);
    exp_tag = '0;
    tick();
    cpu_reset_n = 1'b1;
    tick();
    do_txn(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          dl;
      a = 32'h4000_0000 | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 5) == 0) a = a | $urandom_range(1, 3);
      dl = $urandom_range(0, 3);
      if (TO_EN && $urandom_range(0, 7) == 0) dl = 50;
      do_txn(1'($urandom), a, $urandom, dl, (dl >= 1) && 1'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
